// File: rtl/nonrd_pkg.sv
// Shared types and constants for the nonRD host adapter and its helpers.
package nonrd_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int BUS_W      = 9;

    // Sequencer states: operand load takes three cycles, result read takes two.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_A = 3'd1,
        LD_Q = 3'd2,
        LD_M = 3'd3,
        WAIT = 3'd4,
        RD_Q = 3'd5,
        RESP = 3'd6
    } state_e;

    // Response status codes as seen on rsp_err.
    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_OVF  = 2'b10,
        ERR_TMO  = 2'b11
    } err_e;

    // The quotient fits in DIVISOR_W bits only when the upper dividend half
    // is strictly below the divisor.
    function automatic logic quot_overflows(
        input logic [DIVIDEND_W-1:0] dividend,
        input logic [DIVISOR_W-1:0]  divisor
    );
        return dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor;
    endfunction

endpackage

// File: rtl/nonrd_host_adapter_if.sv
// Request/response channels plus the divider-facing operand/result bus.
interface nonrd_host_adapter_if;
    import nonrd_pkg::*;

    // Request channel
    logic                  req_valid;
    logic                  req_ready;
    logic [DIVIDEND_W-1:0] req_dividend;
    logic [DIVISOR_W-1:0]  req_divisor;

    // Divider side
    logic                  bgn;
    logic [BUS_W-1:0]      inbus;
    logic                  done;
    logic [BUS_W-1:0]      outbus;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DIVISOR_W-1:0]  rsp_quot;
    logic [DIVISOR_W-1:0]  rsp_rem;
    logic [1:0]            rsp_err;

    // Adapter view
    modport slave (
        input  req_valid, req_dividend, req_divisor, done, outbus, rsp_ready,
        output req_ready, bgn, inbus, rsp_valid, rsp_quot, rsp_rem, rsp_err
    );

    // Host/divider environment view
    modport master (
        output req_valid, req_dividend, req_divisor, done, outbus, rsp_ready,
        input  req_ready, bgn, inbus, rsp_valid, rsp_quot, rsp_rem, rsp_err
    );

endinterface

// File: rtl/nonrd_wait_timer.sv
// Watchdog counter for the WAIT state: cleared before the wait begins,
// counts while enabled and saturates at TIMEOUT-1, where expired is raised.
module nonrd_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear wins, otherwise step while enabled and not saturated.
    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for flops so all state updates see pre-edge values.
        if (rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nonrd_host_adapter.sv
// Host-side sequencer for the nonRD divider: screens requests, drives the
// three-cycle operand load, collects remainder/quotient and returns a
// response. Every output is a flop, so nothing on the request or response
// handshake reaches an output combinationally.
module nonrd_host_adapter
    import nonrd_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst_b,
    nonrd_host_adapter_if.slave bus
);

    // FSM state and registered outputs
    state_e                state_q,       state_d;
    logic                  req_ready_q,   req_ready_d;
    logic                  bgn_q,         bgn_d;
    logic [BUS_W-1:0]      inbus_q,       inbus_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic [DIVISOR_W-1:0]  rsp_quot_q,    rsp_quot_d;
    logic [DIVISOR_W-1:0]  rsp_rem_q,     rsp_rem_d;
    err_e                  rsp_err_q,     rsp_err_d;

    // Operands kept for the later load cycles; the upper dividend byte goes
    // out straight from the request in the accept cycle.
    logic [DIVISOR_W-1:0]  dividend_lo_q, dividend_lo_d;
    logic [DIVISOR_W-1:0]  divisor_q,     divisor_d;

    // Watchdog handshake
    logic                  timer_clr;
    logic                  timer_en;
    logic                  timer_expired;

    // outbus[8] carries nothing the adapter needs.
    logic                  outbus_unused;
    assign outbus_unused = bus.outbus[BUS_W-1];

    assign timer_clr = (state_q == LD_M);
    assign timer_en  = (state_q == WAIT);

    nonrd_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_b   (rst_b),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Next state and next output values; outputs are computed for the state
    // being entered so they are valid for that whole cycle.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = 1'b0;
        bgn_d         = 1'b0;
        inbus_d       = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_quot_d    = rsp_quot_q;
        rsp_rem_d     = rsp_rem_q;
        rsp_err_d     = rsp_err_q;
        dividend_lo_d = dividend_lo_q;
        divisor_d     = divisor_q;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    req_ready_d   = 1'b0;
                    dividend_lo_d = bus.req_dividend[DIVISOR_W-1:0];
                    divisor_d     = bus.req_divisor;
                    rsp_quot_d    = '0;
                    rsp_rem_d     = '0;
                    if (bus.req_divisor == '0) begin
                        state_d     = RESP;
                        rsp_err_d   = ERR_DIV0;
                        rsp_valid_d = 1'b1;
                    end else if (quot_overflows(bus.req_dividend, bus.req_divisor)) begin
                        state_d     = RESP;
                        rsp_err_d   = ERR_OVF;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d   = LD_A;
                        rsp_err_d = ERR_OK;
                        bgn_d     = 1'b1;
                        inbus_d   = {1'b0, bus.req_dividend[DIVIDEND_W-1:DIVISOR_W]};
                    end
                end
            end

            LD_A: begin
                state_d = LD_Q;
                inbus_d = {1'b0, dividend_lo_q};
            end

            LD_Q: begin
                state_d = LD_M;
                inbus_d = {1'b0, divisor_q};
            end

            LD_M: begin
                state_d = WAIT;
            end

            WAIT: begin
                // A done in the last allowed cycle still wins over the watchdog.
                if (bus.done) begin
                    state_d   = RD_Q;
                    rsp_rem_d = bus.outbus[DIVISOR_W-1:0];
                end else if (timer_expired) begin
                    state_d     = RESP;
                    rsp_err_d   = ERR_TMO;
                    rsp_quot_d  = '0;
                    rsp_rem_d   = '0;
                    rsp_valid_d = 1'b1;
                end
            end

            RD_Q: begin
                state_d     = RESP;
                rsp_quot_d  = bus.outbus[DIVISOR_W-1:0];
                rsp_err_d   = ERR_OK;
                rsp_valid_d = 1'b1;
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: every flop here is small control/data state, so all of it is reset.
        if (rst_b) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            bgn_q         <= 1'b0;
            inbus_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_quot_q    <= '0;
            rsp_rem_q     <= '0;
            rsp_err_q     <= ERR_OK;
            dividend_lo_q <= '0;
            divisor_q     <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            bgn_q         <= bgn_d;
            inbus_q       <= inbus_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_quot_q    <= rsp_quot_d;
            rsp_rem_q     <= rsp_rem_d;
            rsp_err_q     <= rsp_err_d;
            dividend_lo_q <= dividend_lo_d;
            divisor_q     <= divisor_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.bgn       = bgn_q;
    assign bus.inbus     = inbus_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_quot  = rsp_quot_q;
    assign bus.rsp_rem   = rsp_rem_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_nonrd_host_adapter.sv
// Self-checking bench for nonrd_host_adapter: directed corner cases plus
// randomized requests, with a behavioural divider and an arithmetic
// reference model for the expected response.
module tb_nonrd_host_adapter;
    import nonrd_pkg::*;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    nonrd_host_adapter_if bus_if ();

    nonrd_host_adapter #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] err;
        logic [7:0] quot;
        logic [7:0] rem;
    } rsp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected response from plain integer division.
    function automatic rsp_t ref_model(input logic [15:0] dvd, input logic [7:0] dvs,
                                       input bit silent);
        rsp_t res;
        int   q;
        int   r;
        res.err  = 2'b00;
        res.quot = 8'h00;
        res.rem  = 8'h00;
        if (dvs == 8'h00) begin
            res.err = 2'b01;
        end else begin
            q = int'(dvd) / int'(dvs);
            r = int'(dvd) % int'(dvs);
            if (q > 255) begin
                res.err = 2'b10;
            end else if (silent) begin
                res.err = 2'b11;
            end else begin
                res.quot = q[7:0];
                res.rem  = r[7:0];
            end
        end
        return res;
    endfunction

    // One full request/response exchange, starting and ending at a negedge
    // with the adapter idle. lat = WAIT cycles before the divider's first
    // done; silent = divider never answers; hold = cycles of backpressure.
    task automatic run_txn(input logic [15:0] dvd, input logic [7:0] dvs,
                           input int lat, input bit silent, input int hold);
        rsp_t exp;
        int   waited;
        logic b8;
        exp = ref_model(dvd, dvs, silent);

        check("req_ready_idle", bus_if.req_ready, 1);
        bus_if.req_valid    = 1'b1;
        bus_if.req_dividend = dvd;
        bus_if.req_divisor  = dvs;
        @(negedge clk);  // cycle k+1
        bus_if.req_valid    = 1'b0;
        bus_if.req_dividend = 16'($urandom);
        bus_if.req_divisor  = 8'($urandom);

        if (exp.err == 2'b01 || exp.err == 2'b10) begin
            check("err_bgn", bus_if.bgn, 0);
            check("err_inbus", bus_if.inbus, 0);
        end else begin
            check("lda_bgn", bus_if.bgn, 1);
            check("lda_inbus", bus_if.inbus, {1'b0, dvd[15:8]});
            check("lda_req_ready", bus_if.req_ready, 0);
            @(negedge clk);
            check("ldq_bgn", bus_if.bgn, 0);
            check("ldq_inbus", bus_if.inbus, {1'b0, dvd[7:0]});
            @(negedge clk);
            check("ldm_bgn", bus_if.bgn, 0);
            check("ldm_inbus", bus_if.inbus, {1'b0, dvs});
            @(negedge clk);  // first WAIT cycle
            check("wait_inbus", bus_if.inbus, 0);
            if (silent) begin
                waited = 0;
                while (!bus_if.rsp_valid && waited < 4 * TIMEOUT) begin
                    @(negedge clk);
                    waited++;
                end
                check("tmo_latency", waited, TIMEOUT);
            end else begin
                repeat (lat) @(negedge clk);
                check("wait_rsp_valid", bus_if.rsp_valid, 0);
                b8 = 1'($urandom_range(0, 1));
                bus_if.done   = 1'b1;
                bus_if.outbus = {b8, exp.rem};
                @(negedge clk);
                check("rdq_rsp_valid", bus_if.rsp_valid, 0);
                bus_if.outbus = {~b8, exp.quot};
                @(negedge clk);
                bus_if.done   = 1'b0;
                bus_if.outbus = 9'($urandom);
            end
        end

        check("rsp_valid", bus_if.rsp_valid, 1);
        check("rsp_err", bus_if.rsp_err, exp.err);
        check("rsp_quot", bus_if.rsp_quot, exp.quot);
        check("rsp_rem", bus_if.rsp_rem, exp.rem);

        // Backpressure: a competing request must not be taken, outputs hold.
        for (int i = 0; i < hold; i++) begin
            bus_if.req_valid    = 1'b1;
            bus_if.req_dividend = 16'h0001;
            bus_if.req_divisor  = 8'h00;
            @(negedge clk);
            check("bp_rsp_valid", bus_if.rsp_valid, 1);
            check("bp_req_ready", bus_if.req_ready, 0);
            check("bp_bgn", bus_if.bgn, 0);
            check("bp_hold", {bus_if.rsp_err, bus_if.rsp_quot, bus_if.rsp_rem},
                  {exp.err, exp.quot, exp.rem});
        end

        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        check("post_rsp_valid", bus_if.rsp_valid, 0);
        check("post_req_ready", bus_if.req_ready, 1);
        check("post_bgn", bus_if.bgn, 0);
    endtask

    // Reset asserted for one cycle while waiting on the divider, then a
    // stray done that must not produce a response.
    task automatic reset_mid_wait();
        bus_if.req_valid    = 1'b1;
        bus_if.req_dividend = 16'h03E8;
        bus_if.req_divisor  = 8'h07;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check("rst_req_ready", bus_if.req_ready, 1);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        check("rst_bgn", bus_if.bgn, 0);
        check("rst_inbus", bus_if.inbus, 0);
        check("rst_rsp_err", bus_if.rsp_err, 0);
        bus_if.done   = 1'b1;
        bus_if.outbus = 9'h055;
        repeat (2) @(negedge clk);
        bus_if.done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_rsp_valid", bus_if.rsp_valid, 0);
            check("stray_req_ready", bus_if.req_ready, 1);
        end
    endtask

    // Bounded run time.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] dvs;
        logic [7:0] hi;
        int         sel;

        rst_b               = 1'b1;
        bus_if.req_valid    = 1'b0;
        bus_if.req_dividend = '0;
        bus_if.req_divisor  = '0;
        bus_if.done         = 1'b0;
        bus_if.outbus       = '0;
        bus_if.rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;

        check("reset_req_ready", bus_if.req_ready, 1);
        check("reset_rsp_valid", bus_if.rsp_valid, 0);
        check("reset_bgn", bus_if.bgn, 0);
        check("reset_inbus", bus_if.inbus, 0);
        check("reset_rsp", {bus_if.rsp_err, bus_if.rsp_quot, bus_if.rsp_rem}, 0);

        // Stray done while idle.
        bus_if.done = 1'b1;
        repeat (2) @(negedge clk);
        bus_if.done = 1'b0;
        @(negedge clk);
        check("idle_done_rsp_valid", bus_if.rsp_valid, 0);

        run_txn(16'h03E8, 8'h07, 3, 1'b0, 0);          // nominal
        run_txn(16'h1234, 8'h00, 0, 1'b0, 0);          // divide-by-zero
        run_txn(16'h0800, 8'h08, 0, 1'b0, 0);          // overflow, hi == divisor
        run_txn(16'hFEFF, 8'hFF, 1, 1'b0, 0);          // largest legal quotient
        run_txn(16'h03E8, 8'h07, 0, 1'b1, 1);          // timeout
        run_txn(16'h03E8, 8'h07, TIMEOUT - 1, 1'b0, 0); // done in last WAIT cycle
        run_txn(16'h03E8, 8'h07, 2, 1'b0, 5);          // backpressure
        run_txn(16'h00FF, 8'h01, 0, 1'b0, 0);          // back-to-back after release

        reset_mid_wait();
        run_txn(16'h03E8, 8'h07, 4, 1'b0, 0);          // recovery after reset

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                dvs = 8'h00;
                hi  = 8'($urandom);
            end else begin
                dvs = 8'($urandom_range(1, 255));
                if (sel == 1) hi = 8'($urandom_range(int'(dvs), 255));
                else          hi = 8'($urandom_range(0, int'(dvs) - 1));
            end
            run_txn({hi, 8'($urandom)}, dvs, $urandom_range(0, 12),
                    (sel == 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
